// File: rtl/sdram_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_arbiter
//
// Shares the single command port of the SDRAM controller between N_SRC burst
// requesters such as cache fill/write-back engines, display fetch and DMA.
// One requester is granted at a time, and the grant is held for a complete
// BURST-beat transfer. The arbiter forwards the access descriptor, the write
// beats, the read beats and the per-beat acknowledges.
//
// Optional build macro:
//   SDRAM_ARB_PRIORITY_EN - when defined, source 0 has absolute priority. The
//                           remaining sources share round-robin among
//                           themselves. When undefined, the arbiter is pure
//                           round-robin over all sources.
//
// Parameters:
//   N_SRC  number of requesters (2..16)
//   BURST  beats per granted transfer (power of two, >= 2)
//
// Ports:
//   CLK             system clock
//   RESET_IN        synchronous active-high reset
//   SRC_REQ_IN      per-source burst request level
//   SRC_WRITE_IN    per-source direction (1 = write)
//   SRC_ACS_IN      per-source burst start descriptor
//   SRC_WDATA_IN    per-source current write beat
//   SRC_ACK_OUT     per-beat acknowledge, granted source only
//   SRC_DATA_OUT    read beat broadcast to all sources (valid with ACK)
//   DRAM_REQ_OUT    request to the controller, high for the whole burst
//   DRAM_WRITE_OUT  direction of the granted burst
//   DRAM_ACS_OUT    descriptor of the granted burst
//   DRAM_WDATA_OUT  write beat of the granted source
//   DRAM_DATA_IN    read beat from the controller
//   DRAM_ACK_IN     beat acknowledge from the controller
// -----------------------------------------------------------------------------

package SDRAM_PKG;
  typedef logic [31:0] data_t;

  typedef struct packed {
    logic [1:0]  bank;
    logic [12:0] row;
    logic [9:0]  col;
  } dram_access_t;
endpackage

module sdram_arbiter #(
  parameter int N_SRC = 4,
  parameter int BURST = 8
) (
  input  logic                                 CLK,
  input  logic                                 RESET_IN,
  input  logic [N_SRC-1:0]                     SRC_REQ_IN,
  input  logic [N_SRC-1:0]                     SRC_WRITE_IN,
  input  SDRAM_PKG::dram_access_t [N_SRC-1:0]  SRC_ACS_IN,
  input  SDRAM_PKG::data_t [N_SRC-1:0]         SRC_WDATA_IN,
  output logic [N_SRC-1:0]                     SRC_ACK_OUT,
  output SDRAM_PKG::data_t                     SRC_DATA_OUT,
  output logic                                 DRAM_REQ_OUT,
  output logic                                 DRAM_WRITE_OUT,
  output SDRAM_PKG::dram_access_t              DRAM_ACS_OUT,
  output SDRAM_PKG::data_t                     DRAM_WDATA_OUT,
  input  SDRAM_PKG::data_t                     DRAM_DATA_IN,
  input  logic                                 DRAM_ACK_IN
);

  localparam int IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;

  localparam logic [IW-1:0] LAST_SRC  = IW'(N_SRC - 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [IW-1:0] last_q,  last_d;
  logic [BW-1:0] beat_q,  beat_d;

  logic [IW-1:0] winner_s;
  logic          found_s;
  logic          busy_s;

  assign busy_s = (state_q == BUSY);

  // Winner selection: scan from last+1 with wrap, so the most recent winner
  // is visited last. That ordering gives the N_SRC-1 starvation bound.
  always_comb begin
    logic          hit_v;
    logic [IW-1:0] idx_v;
    winner_s = '0;
    found_s  = 1'b0;
`ifdef SDRAM_ARB_PRIORITY_EN
    // Source 0 pre-empts the rotation. The scan below skips it.
    found_s  = SRC_REQ_IN[0];
    winner_s = '0;
`endif
    for (int i = 1; i <= N_SRC; i++) begin
      idx_v = IW'((int'(last_q) + i) % N_SRC);
`ifdef SDRAM_ARB_PRIORITY_EN
      hit_v = !found_s && SRC_REQ_IN[idx_v] && (idx_v != '0);
`else
      hit_v = !found_s && SRC_REQ_IN[idx_v];
`endif
      winner_s = hit_v ? idx_v : winner_s;
      found_s  = found_s | hit_v;
    end
  end

  // Next-state logic for the grant FSM, the rotation pointer and the beat counter.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    beat_d  = beat_q;
    case (state_q)
      IDLE: begin
        if (found_s) begin
          state_d = BUSY;
          grant_d = winner_s;
          beat_d  = '0;
`ifdef SDRAM_ARB_PRIORITY_EN
          // Priority grants to source 0 leave the rotation where it was.
          if (winner_s != '0) begin
            last_d = winner_s;
          end else begin
            last_d = last_q;
          end
`else
          last_d  = winner_s;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (DRAM_ACK_IN) begin
          // The counter is BURST-sized, so it wraps to 0 on the last beat.
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) begin
            state_d = IDLE;
          end else begin
            state_d = BUSY;
          end
        end else begin
          state_d = BUSY;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous reset. A reset mid-burst drops the remaining beats.
  always_ff @(posedge CLK) begin
    if (RESET_IN) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= LAST_SRC;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
    end
  end

  // Per-beat acknowledge routed to the granted source with zero added latency.
  // Stray acknowledges while idle are swallowed.
  always_comb begin
    SRC_ACK_OUT = '0;
    if (busy_s && DRAM_ACK_IN) begin
      SRC_ACK_OUT[grant_q] = 1'b1;
    end else begin
      SRC_ACK_OUT = '0;
    end
  end

  // Controller-side command path. The muxes follow the grant even while idle.
  assign DRAM_REQ_OUT   = busy_s;
  assign DRAM_WRITE_OUT = SRC_WRITE_IN[grant_q];
  assign DRAM_ACS_OUT   = SRC_ACS_IN[grant_q];
  assign DRAM_WDATA_OUT = SRC_WDATA_IN[grant_q];

  // Read data is broadcast. A source qualifies it with its own ACK.
  assign SRC_DATA_OUT   = DRAM_DATA_IN;

endmodule

// File: tb/tb_sdram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sdram_arbiter
//
// Directed testbench for sdram_arbiter with N_SRC=4 and BURST=8. A small
// controller model issues beat ACKs separated by random idle gaps. Expected
// grant orders and data are written out by hand for each scenario.
// -----------------------------------------------------------------------------

module tb_sdram_arbiter;

  localparam int N_SRC = 4;
  localparam int BURST = 8;

  logic                               clk_s;
  logic                               rst_s;
  logic [N_SRC-1:0]                   req_s;
  logic [N_SRC-1:0]                   write_s;
  SDRAM_PKG::dram_access_t [N_SRC-1:0] acs_s;
  SDRAM_PKG::data_t [N_SRC-1:0]       wdata_s;
  logic [N_SRC-1:0]                   src_ack_s;
  SDRAM_PKG::data_t                   src_data_s;
  logic                               dram_req_s;
  logic                               dram_write_s;
  SDRAM_PKG::dram_access_t            dram_acs_s;
  SDRAM_PKG::data_t                   dram_wdata_s;
  SDRAM_PKG::data_t                   dram_data_s;
  logic                               dram_ack_s;

  int checks_cnt;
  int errors_cnt;
  logic [31:0] wbase_s;

  sdram_arbiter #(
    .N_SRC (N_SRC),
    .BURST (BURST)
  ) dut (
    .CLK            (clk_s),
    .RESET_IN       (rst_s),
    .SRC_REQ_IN     (req_s),
    .SRC_WRITE_IN   (write_s),
    .SRC_ACS_IN     (acs_s),
    .SRC_WDATA_IN   (wdata_s),
    .SRC_ACK_OUT    (src_ack_s),
    .SRC_DATA_OUT   (src_data_s),
    .DRAM_REQ_OUT   (dram_req_s),
    .DRAM_WRITE_OUT (dram_write_s),
    .DRAM_ACS_OUT   (dram_acs_s),
    .DRAM_WDATA_OUT (dram_wdata_s),
    .DRAM_DATA_IN   (dram_data_s),
    .DRAM_ACK_IN    (dram_ack_s)
  );

  // Free-running clock, 10 time-unit period.
  initial clk_s = 1'b0;
  always #5 clk_s = ~clk_s;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and move 1 time unit past the edge.
  task automatic tick();
    @(posedge clk_s);
    #1;
  endtask

  task automatic pulse_reset();
    rst_s = 1'b1;
    tick();
    tick();
    rst_s = 1'b0;
  endtask

  // Controller model for one granted burst. It gives n_beats ACKs with random
  // gaps and checks the routing, mux and data path on every beat. When
  // drop_after >= 0, the source drops its request after that beat.
  task automatic run_burst(input int src, input int n_beats, input int drop_after);
    logic [N_SRC-1:0] onehot;
    onehot      = '0;
    onehot[src] = 1'b1;
    check_val("req_granted", 32'(dram_req_s), 32'h1);
    for (int b = 0; b < n_beats; b++) begin
      repeat ($urandom_range(0, 2)) begin
        dram_ack_s = 1'b0;
        #1;
        check_val("gap_no_ack", 32'(src_ack_s), 32'h0);
        check_val("gap_req_held", 32'(dram_req_s), 32'h1);
        tick();
      end
      dram_ack_s  = 1'b1;
      dram_data_s = $urandom;
      #1;
      check_val("beat_ack", 32'(src_ack_s), 32'(onehot));
      check_val("beat_rdata", src_data_s, dram_data_s);
      check_val("beat_acs", 32'(dram_acs_s), 32'(acs_s[src]));
      check_val("beat_write", 32'(dram_write_s), 32'(write_s[src]));
      if (write_s[src]) begin
        check_val("beat_wdata", dram_wdata_s, wbase_s + 32'(b));
      end
      tick();
      dram_ack_s = 1'b0;
      if (write_s[src]) begin
        wdata_s[src] = wbase_s + 32'(b + 1);
      end
      if (b == drop_after) begin
        req_s[src] = 1'b0;
      end
    end
    if (n_beats == BURST) begin
      check_val("bubble_req_low", 32'(dram_req_s), 32'h0);
      check_val("bubble_no_ack", 32'(src_ack_s), 32'h0);
    end
  endtask

  // Arbitration edge, then a full burst for the expected winner.
  task automatic do_burst(input int src);
    tick();
    run_burst(src, BURST, -1);
  endtask

  initial begin
    int order[5];
    checks_cnt  = 0;
    errors_cnt  = 0;
    rst_s       = 1'b1;
    req_s       = '0;
    write_s     = '0;
    dram_ack_s  = 1'b0;
    dram_data_s = '0;
    wbase_s     = 32'h0;
    for (int i = 0; i < N_SRC; i++) begin
      acs_s[i]   = SDRAM_PKG::dram_access_t'(25'(32'h00A0_0000 + 32'(i) * 32'h0001_1111));
      wdata_s[i] = 32'hC0DE_0000 + 32'(i);
    end

    // Reset state: idle, no ACK, muxes showing source 0.
    pulse_reset();
    check_val("rst_req", 32'(dram_req_s), 32'h0);
    check_val("rst_ack", 32'(src_ack_s), 32'h0);
    check_val("rst_acs_mux", 32'(dram_acs_s), 32'(acs_s[0]));
    dram_ack_s = 1'b1;
    #1;
    check_val("idle_stray_ack", 32'(src_ack_s), 32'h0);
    dram_ack_s = 1'b0;

    // Single read from source 0. REQ rises one cycle after the request.
    req_s = 4'b0001;
    #1;
    check_val("req_latency", 32'(dram_req_s), 32'h0);
    do_burst(0);
    req_s = 4'b0000;

    // All four requesting continuously.
    pulse_reset();
`ifdef SDRAM_ARB_PRIORITY_EN
    order = '{0, 0, 0, 0, 0};
`else
    order = '{0, 1, 2, 3, 0};
`endif
    req_s = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      do_burst(order[k]);
    end
    req_s = 4'b0000;

    // Source 2 write burst with WDATA 0x10..0x17.
    wbase_s    = 32'h10;
    wdata_s[2] = 32'h10;
    write_s[2] = 1'b1;
    req_s      = 4'b0100;
    do_burst(2);
    req_s      = 4'b0000;
    write_s[2] = 1'b0;

    // Source 1 drops REQ after beat 3. Source 3 arrives mid-burst and waits.
    req_s = 4'b0010;
    tick();
    req_s = 4'b1010;
    run_burst(1, BURST, 3);
    do_burst(3);
    req_s = 4'b0000;

    // Reset at beat 5 of a source 2 burst.
    req_s = 4'b0100;
    tick();
    run_burst(2, 5, -1);
    rst_s = 1'b1;
    tick();
    rst_s      = 1'b0;
    req_s      = 4'b0000;
    dram_ack_s = 1'b1;
    #1;
    check_val("abort_req", 32'(dram_req_s), 32'h0);
    check_val("abort_stray_ack", 32'(src_ack_s), 32'h0);
    tick();
    dram_ack_s = 1'b0;
    #1;
    check_val("abort_still_idle", 32'(dram_req_s), 32'h0);
    req_s = 4'b0101;
    do_burst(0);
    req_s = 4'b0000;

`ifdef SDRAM_ARB_PRIORITY_EN
    // Source 0 beats source 3 every time. Then round-robin resumes among 1..3.
    pulse_reset();
    req_s = 4'b1001;
    do_burst(0);
    do_burst(0);
    req_s = 4'b1110;
    do_burst(1);
    do_burst(2);
    do_burst(3);
    req_s = 4'b0000;
`endif

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
